// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons sharing runtime-writable threshold, leak and refractory registers.
// Optional winner-take-all lateral inhibition is compiled in when LIF_INHIBIT_EN is defined.
module lif_neuron_array #(
    parameter int N_NEURONS  = 4,
    parameter int V_WIDTH    = 8,
    parameter int I_WIDTH    = 3,
    parameter int REF_WIDTH  = 8,
    parameter int THRESH_RST = 16,
    parameter int LEAK_RST   = 1,
    parameter int REF_RST    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic [N_NEURONS*I_WIDTH-1:0] input_current,
    input  logic                         cfg_we,
    input  logic [1:0]                   cfg_addr,
    input  logic [V_WIDTH-1:0]           cfg_data,
    input  logic [2:0]                   mon_sel,
    output logic [N_NEURONS-1:0]         spike_out,
    output logic                         spike_any,
    output logic [V_WIDTH-1:0]           v_mon
);

    localparam int SW = V_WIDTH + 1;

    logic [V_WIDTH-1:0]   r_thr;
    logic [V_WIDTH-1:0]   r_leak;
    logic [REF_WIDTH-1:0] r_ref;
    logic [V_WIDTH-1:0]   r_v [N_NEURONS];
    logic [REF_WIDTH-1:0] r_r [N_NEURONS];
    logic [N_NEURONS-1:0] r_spike;
    logic                 r_spike_any;
    logic [V_WIDTH-1:0]   r_vmon;

    logic [V_WIDTH-1:0]   w_vnext [N_NEURONS];
    logic [V_WIDTH-1:0]   w_vupd  [N_NEURONS];
    logic [N_NEURONS-1:0] w_fire;
    logic [N_NEURONS-1:0] w_refr;
    logic [V_WIDTH-1:0]   w_vsel;

    // Integrate and leak at one extra bit, floor at zero, saturate at full scale.
    function automatic logic [V_WIDTH-1:0] leak_sat(
        input logic [V_WIDTH-1:0] v,
        input logic [I_WIDTH-1:0] i,
        input logic [V_WIDTH-1:0] leak
    );
        logic [SW-1:0] s;
        logic [SW-1:0] d;
        s = {1'b0, v} + SW'(i);
        if (s <= {1'b0, leak})
            d = '0;
        else
            d = s - {1'b0, leak};
        if (d[V_WIDTH])
            return {V_WIDTH{1'b1}};
        else
            return d[V_WIDTH-1:0];
    endfunction

    always_comb begin
        for (int k = 0; k < N_NEURONS; k++) begin
            w_refr[k]  = (r_r[k] != '0);
            w_vnext[k] = leak_sat(r_v[k], input_current[k*I_WIDTH +: I_WIDTH], r_leak);
            w_fire[k]  = !w_refr[k] && (r_thr != '0) && (w_vnext[k] >= r_thr);
        end
    end

    // Non-firing neurons either keep their integrated value or are suppressed by a winner.
    always_comb begin
        for (int k = 0; k < N_NEURONS; k++) begin
`ifdef LIF_INHIBIT_EN
            w_vupd[k] = (|w_fire) ? '0 : w_vnext[k];
`else
            w_vupd[k] = w_vnext[k];
`endif
        end
    end

    // Out-of-range selections fall through to zero.
    always_comb begin
        w_vsel = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            if (mon_sel == 3'(k))
                w_vsel = r_v[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thr  <= V_WIDTH'(THRESH_RST);
            r_leak <= V_WIDTH'(LEAK_RST);
            r_ref  <= REF_WIDTH'(REF_RST);
        end else if (cfg_we) begin
            case (cfg_addr)
                2'd0:    r_thr  <= cfg_data;
                2'd1:    r_leak <= cfg_data;
                2'd2:    r_ref  <= cfg_data[REF_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                r_v[k] <= '0;
                r_r[k] <= '0;
            end
        end else if (ena) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                if (w_refr[k]) begin
                    r_r[k] <= r_r[k] - 1'b1;
                    r_v[k] <= '0;
                end else if (w_fire[k]) begin
                    r_r[k] <= r_ref;
                    r_v[k] <= '0;
                end else begin
                    r_v[k] <= w_vupd[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike     <= '0;
            r_spike_any <= 1'b0;
            r_vmon      <= '0;
        end else begin
            r_spike     <= ena ? w_fire : '0;
            r_spike_any <= ena && (|w_fire);
            r_vmon      <= w_vsel;
        end
    end

    assign spike_out = r_spike;
    assign spike_any = r_spike_any;
    assign v_mon     = r_vmon;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed-vector bench for lif_neuron_array; expectations adapt to LIF_INHIBIT_EN.
module tb_lif_neuron_array;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [11:0] input_current;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic [2:0]  mon_sel;
    logic [3:0]  spike_out;
    logic        spike_any;
    logic [7:0]  v_mon;

    int n_checks;
    int n_fail;

    lif_neuron_array dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .input_current(input_current),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .mon_sel      (mon_sel),
        .spike_out    (spike_out),
        .spike_any    (spike_any),
        .v_mon        (v_mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cur(input int i0, input int i1, input int i2, input int i3);
        input_current = {3'(i3), 3'(i2), 3'(i1), 3'(i0)};
    endtask

    // One clock edge; inputs change and outputs are sampled on the falling edge.
    task automatic step(input logic e);
        ena = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step(1'b0);
        cfg_we   = 1'b0;
    endtask

    task automatic do_reset();
        ena   = 1'b0;
        cur(0, 0, 0, 0);
        mon_sel = 3'd0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_v [9];
        int exp_s [9];
        logic seen;
        int nsp;
        int idx;
        int en_n;
        int fire_at;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        ena      = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = 2'd0;
        cfg_data = 8'd0;
        mon_sel  = 3'd0;
        input_current = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_spike_out", spike_out, 0);
        chk("rst_spike_any", spike_any, 0);
        chk("rst_v_mon", v_mon, 0);
        rst_n = 1'b1;

        // Default registers: THR=16, LEAK=1 -> fires on the 8th tick with I=3
        cur(3, 0, 0, 0);
        for (int t = 1; t <= 8; t++) begin
            step(1'b1);
            if (t == 7) chk("dflt_no_spike_t7", spike_out, 0);
        end
        chk("dflt_spike_t8", spike_out, 1);
        chk("dflt_vmon_t8", v_mon, 14);

        // Basic integrate / fire / refractory sequence
        do_reset();
        cfg_write(2'd0, 8'd10);
        cfg_write(2'd1, 8'd1);
        cfg_write(2'd2, 8'd2);
        cur(3, 0, 0, 0);
        exp_v = '{0, 2, 4, 6, 8, 0, 0, 0, 2};
        exp_s = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        for (int t = 0; t < 9; t++) begin
            step(1'b1);
            chk($sformatf("basic_vmon_t%0d", t + 1), v_mon, exp_v[t]);
            chk($sformatf("basic_spike_t%0d", t + 1), spike_out, exp_s[t]);
            chk($sformatf("basic_any_t%0d", t + 1), spike_any, exp_s[t]);
        end

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_vmon", v_mon, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Leak floor
        do_reset();
        cfg_write(2'd0, 8'd20);
        cfg_write(2'd1, 8'd5);
        cur(2, 0, 0, 0);
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            step(1'b1);
            seen |= spike_any;
        end
        chk("leak_no_spike", seen, 0);
        chk("leak_vmon", v_mon, 0);

        // Saturation with firing disabled
        do_reset();
        cfg_write(2'd0, 8'd0);
        cfg_write(2'd1, 8'd0);
        cur(7, 0, 0, 0);
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            step(1'b1);
            seen |= spike_any;
        end
        chk("sat_vmon", v_mon, 255);
        step(1'b1);
        seen |= spike_any;
        chk("sat_vmon_hold", v_mon, 255);
        chk("sat_no_spike", seen, 0);
        mon_sel = 3'd5;
        step(1'b0);
        chk("mon_out_of_range", v_mon, 0);
        mon_sel = 3'd0;
        step(1'b0);
        chk("mon_back", v_mon, 255);

        // Config write colliding with a tick uses the old threshold
        do_reset();
        cfg_write(2'd0, 8'd10);
        cfg_write(2'd1, 8'd1);
        cur(3, 0, 0, 0);
        for (int t = 0; t < 4; t++) step(1'b1);
        cfg_we   = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = 8'd20;
        step(1'b1);
        cfg_we = 1'b0;
        chk("coll_fire_old_thr", spike_out, 1);
        nsp = 0;
        idx = 0;
        for (int t = 1; t <= 12; t++) begin
            step(1'b1);
            if (spike_out[0]) begin
                nsp++;
                idx = t;
            end
        end
        chk("coll_new_thr_count", nsp, 1);
        chk("coll_new_thr_tick", idx, 12);

        // ena gating
        do_reset();
        cfg_write(2'd0, 8'd10);
        cfg_write(2'd1, 8'd1);
        cur(3, 0, 0, 0);
        en_n = 0;
        fire_at = 0;
        nsp = 0;
        for (int c = 0; c < 12; c++) begin
            if (c % 2 == 0) begin
                step(1'b1);
                en_n++;
                if (spike_out[0]) begin
                    nsp++;
                    fire_at = en_n;
                end
            end else begin
                step(1'b0);
                chk($sformatf("gate_quiet_c%0d", c), spike_out, 0);
            end
        end
        chk("gate_fire_at", fire_at, 5);
        chk("gate_spike_count", nsp, 1);

        // Lateral inhibition (or independence when compiled out)
        do_reset();
        cfg_write(2'd0, 8'd12);
        cfg_write(2'd1, 8'd0);
        cur(7, 3, 0, 0);
        mon_sel = 3'd1;
        step(1'b1);
        step(1'b1);
        chk("inh_n0_fires", spike_out, 1);
        chk("inh_vmon_t2", v_mon, 3);
        step(1'b1);
`ifdef LIF_INHIBIT_EN
        chk("inh_n1_cleared", v_mon, 0);
`else
        chk("inh_n1_holds", v_mon, 6);
`endif
        step(1'b1);
`ifdef LIF_INHIBIT_EN
        chk("inh_n1_no_fire_t4", spike_out, 0);
`else
        chk("inh_n1_fire_t4", spike_out, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
